gigamax_bus_n: RTL and testbench

Parametrised, deterministic successor of the three-processor Gigamax snooping-bus coherence model. It holds a single cache line shared by `NPROC` processors and one memory. It models the following per-processor state:

- MSI-style status: invalid/shared/owned
- snoop obligation
- read-waiting bit

Arbitration is round-robin, and memory response latency is programmable. All former nondeterministic choices are replaced by explicit request/stall inputs, so the block can be simulated and formally checked against a coherence invariant.

---
 rtl/gigamax_bus_n.sv | 172 +++++++++++++++++
 tb/tb_gigamax_bus_n.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gigamax_bus_n.sv
// Single-line snooping-bus coherence controller for NPROC processors and one memory.
// Round-robin bus arbitration, programmable memory latency, sticky coherence checker.
//
// line status | meaning
// ST_INV      | no copy held
// ST_SHD      | read-only copy held
// ST_OWN      | exclusive owner; snoop holds the pending write-back kind
module gigamax_bus_n #(
    parameter int NPROC   = 3,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NPROC-1:0]     req_valid,
    input  logic [NPROC-1:0]     req_excl,
    input  logic [NPROC-1:0]     evict,
    input  logic [NPROC-1:0]     stall_in,
    output logic [NPROC-1:0]     grant,
    output logic                 mem_grant,
    output logic [3:0]           bus_cmd,
    output logic                 abort,
    output logic [2*NPROC-1:0]   line_state,
    output logic [NPROC-1:0]     waiting,
    output logic                 mem_busy,
    output logic                 coherence_err
);
    localparam int RW = $clog2(NPROC);

    typedef enum logic [1:0] {ST_INV = 2'd0, ST_SHD = 2'd1, ST_OWN = 2'd2} st_e;
    typedef enum logic [3:0] {
        CMD_IDLE = 4'd0, CMD_RS = 4'd1, CMD_RO = 4'd2, CMD_WI = 4'd3, CMD_WS = 4'd4,
        CMD_WRI = 4'd5, CMD_WRS = 4'd6, CMD_INVAL = 4'd7, CMD_RESP = 4'd8
    } cmd_e;

    st_e              st_q    [NPROC];
    st_e              snoop_q [NPROC];
    logic [NPROC-1:0] wait_q;
    logic             busy_q;
    logic [3:0]       cnt_q;
    logic [RW-1:0]    rr_q;
    logic             err_q;

    cmd_e             cand [NPROC];
    cmd_e             cmd;
    logic [RW-1:0]    m_idx;
    logic             m_vld;
    logic             found;
    logic             is_read;
    logic             is_write;
    logic             any_owned;
    logic             any_shd;
    int               n_own;
    logic             viol;

    always_comb begin
        for (int p = 0; p < NPROC; p++) begin
            cand[p] = CMD_IDLE;
            if (st_q[p] == ST_OWN && snoop_q[p] != ST_INV)
                cand[p] = (snoop_q[p] == ST_OWN) ? CMD_WRI : CMD_WRS;
            else if (st_q[p] == ST_OWN && evict[p])
                cand[p] = CMD_WI;
            else if (st_q[p] == ST_INV && req_valid[p] && !wait_q[p])
                cand[p] = req_excl[p] ? CMD_RO : CMD_RS;
            else if (st_q[p] == ST_SHD && req_valid[p] && req_excl[p])
                cand[p] = CMD_INVAL;
        end
    end

    // Memory response beats snoop write-backs, which beat round-robin requests.
    always_comb begin
        mem_grant = 1'b0;
        grant     = '0;
        cmd       = CMD_IDLE;
        m_idx     = '0;
        m_vld     = 1'b0;
        found     = 1'b0;
        if (busy_q && cnt_q == 4'd0) begin
            mem_grant = 1'b1;
            cmd       = CMD_RESP;
        end else begin
            for (int p = 0; p < NPROC; p++) begin
                if (!found && st_q[p] == ST_OWN && snoop_q[p] != ST_INV) begin
                    found = 1'b1;
                    m_idx = RW'(p);
                end
            end
            for (int i = 0; i < NPROC; i++) begin
                if (!found && cand[(int'(rr_q) + i) % NPROC] != CMD_IDLE) begin
                    found = 1'b1;
                    m_idx = RW'((int'(rr_q) + i) % NPROC);
                end
            end
            if (found) begin
                m_vld        = 1'b1;
                grant[m_idx] = 1'b1;
                cmd          = cand[m_idx];
            end
        end
    end

    always_comb begin
        is_read   = (cmd == CMD_RS) || (cmd == CMD_RO);
        is_write  = (cmd == CMD_WI) || (cmd == CMD_WS) || (cmd == CMD_WRI) || (cmd == CMD_WRS);
        abort     = (|stall_in) || (is_read && |(wait_q & ~grant)) ||
                    (busy_q && (is_read || is_write));
        any_owned = 1'b0;
        any_shd   = 1'b0;
        n_own     = 0;
        for (int p = 0; p < NPROC; p++) begin
            if (st_q[p] == ST_OWN) any_owned = 1'b1;
            if (st_q[p] == ST_SHD) any_shd = 1'b1;
            // an owner still owing a snoop write-back is mid-handoff and exempt
            if (st_q[p] == ST_OWN && snoop_q[p] == ST_INV) n_own = n_own + 1;
        end
        viol = (n_own > 1) || (n_own > 0 && any_shd);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < NPROC; p++) begin
                st_q[p]    <= ST_INV;
                snoop_q[p] <= ST_INV;
            end
            wait_q <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rr_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            for (int p = 0; p < NPROC; p++)
                if (st_q[p] == ST_SHD && evict[p] && !grant[p]) st_q[p] <= ST_INV;
            if (!abort) begin
                for (int p = 0; p < NPROC; p++) begin
                    if (grant[p]) begin
                        case (cmd)
                            CMD_RS:    begin st_q[p] <= ST_SHD; wait_q[p] <= 1'b1; end
                            CMD_RO:    begin st_q[p] <= ST_OWN; wait_q[p] <= 1'b1; end
                            CMD_INVAL: st_q[p] <= ST_OWN;
                            CMD_WI, CMD_WRI: begin st_q[p] <= ST_INV; snoop_q[p] <= ST_INV; end
                            CMD_WRS:   begin st_q[p] <= ST_SHD; snoop_q[p] <= ST_INV; end
                            default:   ;
                        endcase
                    end else begin
                        if (st_q[p] == ST_SHD && (cmd == CMD_RO || cmd == CMD_INVAL))
                            st_q[p] <= ST_INV;
                        if (st_q[p] == ST_OWN && cmd == CMD_RS) snoop_q[p] <= ST_SHD;
                        if (st_q[p] == ST_OWN && cmd == CMD_RO) snoop_q[p] <= ST_OWN;
                        if (wait_q[p] && (cmd == CMD_RESP || cmd == CMD_WRI || cmd == CMD_WRS))
                            wait_q[p] <= 1'b0;
                    end
                end
                if (is_read && !any_owned) begin
                    busy_q <= 1'b1;
                    cnt_q  <= 4'(MEM_LAT);
                end
                if (cmd == CMD_RESP) busy_q <= 1'b0;
                if (m_vld) rr_q <= (m_idx == RW'(NPROC - 1)) ? '0 : m_idx + 1'b1;
            end
            err_q <= err_q | viol;
        end
    end

    always_comb begin
        for (int p = 0; p < NPROC; p++) line_state[2*p +: 2] = st_q[p];
    end

    assign bus_cmd       = cmd;
    assign waiting       = wait_q;
    assign mem_busy      = busy_q;
    assign coherence_err = err_q;
endmodule

// File: tb/tb_gigamax_bus_n.sv
// Directed bench for gigamax_bus_n (NPROC=3, MEM_LAT=2) with hand-computed expectations.
module tb_gigamax_bus_n;
    localparam int NPROC   = 3;
    localparam int MEM_LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NPROC-1:0] req_valid, req_excl, evict, stall_in;
    logic [NPROC-1:0] grant;
    logic             mem_grant;
    logic [3:0]       bus_cmd;
    logic             abort;
    logic [5:0]       line_state;
    logic [NPROC-1:0] waiting;
    logic             mem_busy;
    logic             coherence_err;

    int checks   = 0;
    int failures = 0;
    int n_wait;
    int n_resp;

    gigamax_bus_n #(.NPROC(NPROC), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_excl(req_excl),
        .evict(evict), .stall_in(stall_in), .grant(grant), .mem_grant(mem_grant),
        .bus_cmd(bus_cmd), .abort(abort), .line_state(line_state), .waiting(waiting),
        .mem_busy(mem_busy), .coherence_err(coherence_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] rv, input logic [2:0] ex,
                         input logic [2:0] ev, input logic [2:0] st);
        req_valid = rv;
        req_excl  = ex;
        evict     = ev;
        stall_in  = st;
        #1;
    endtask

    // steps until the memory response is on the bus; cycles waited returned in n
    task automatic wait_resp(output int n);
        n = 0;
        while (bus_cmd != 4'd8 && n < 20) begin
            step();
            n++;
        end
        chk("resp_seen", 32'(bus_cmd), 32'd8);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(3'b000, 3'b000, 3'b000, 3'b000);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_line", 32'(line_state), 32'h0);
        chk("rst_wait", 32'(waiting), 32'h0);
        chk("rst_busy", 32'(mem_busy), 32'h0);
        chk("rst_cmd", 32'(bus_cmd), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);

        // p0 read_shared served by memory
        drive(3'b001, 3'b000, 3'b000, 3'b000);
        chk("rs_cmd", 32'(bus_cmd), 32'd1);
        chk("rs_grant", 32'(grant), 32'b001);
        chk("rs_abort", 32'(abort), 32'd0);
        step();
        drive(3'b000, 3'b000, 3'b000, 3'b000);
        chk("rs_line", 32'(line_state), 32'b000001);
        chk("rs_wait", 32'(waiting), 32'b001);
        chk("rs_busy", 32'(mem_busy), 32'd1);
        wait_resp(n_wait);
        chk("rs_lat", 32'(n_wait), 32'd2);
        chk("rs_memgnt", 32'(mem_grant), 32'd1);
        step();
        chk("rs_wait_clr", 32'(waiting), 32'b000);
        chk("rs_busy_clr", 32'(mem_busy), 32'd0);

        // p1 read_owned kills p0's shared copy
        drive(3'b010, 3'b010, 3'b000, 3'b000);
        chk("ro_cmd", 32'(bus_cmd), 32'd2);
        chk("ro_grant", 32'(grant), 32'b010);
        step();
        drive(3'b000, 3'b000, 3'b000, 3'b000);
        chk("ro_line", 32'(line_state), 32'b001000);
        wait_resp(n_wait);
        step();
        chk("ro_wait_clr", 32'(waiting), 32'b000);

        // p0 read_shared while p1 owns: owner supplies data
        drive(3'b001, 3'b000, 3'b000, 3'b000);
        chk("snp_cmd", 32'(bus_cmd), 32'd1);
        chk("snp_grant", 32'(grant), 32'b001);
        step();
        drive(3'b000, 3'b000, 3'b000, 3'b000);
        chk("snp_line", 32'(line_state), 32'b001001);
        chk("snp_busy", 32'(mem_busy), 32'd0);
        chk("wrs_cmd", 32'(bus_cmd), 32'd6);
        chk("wrs_grant", 32'(grant), 32'b010);
        step();
        chk("wrs_line", 32'(line_state), 32'b000101);
        chk("wrs_wait", 32'(waiting), 32'b000);
        chk("wrs_busy", 32'(mem_busy), 32'd0);

        // p1 upgrades via invalidate
        drive(3'b010, 3'b010, 3'b000, 3'b000);
        chk("inv_cmd", 32'(bus_cmd), 32'd7);
        chk("inv_grant", 32'(grant), 32'b010);
        step();
        drive(3'b000, 3'b000, 3'b000, 3'b000);
        chk("inv_line", 32'(line_state), 32'b001000);
        chk("inv_err", 32'(coherence_err), 32'd0);

        // stalled p0 read_owned, then retry
        drive(3'b001, 3'b001, 3'b000, 3'b100);
        chk("stl_cmd", 32'(bus_cmd), 32'd2);
        chk("stl_abort", 32'(abort), 32'd1);
        step();
        chk("stl_line", 32'(line_state), 32'b001000);
        chk("stl_wait", 32'(waiting), 32'b000);
        drive(3'b001, 3'b001, 3'b000, 3'b000);
        chk("rty_grant", 32'(grant), 32'b001);
        chk("rty_abort", 32'(abort), 32'd0);
        step();
        drive(3'b000, 3'b000, 3'b000, 3'b000);
        chk("rty_line", 32'(line_state), 32'b001010);
        chk("rty_wait", 32'(waiting), 32'b001);
        chk("rty_busy", 32'(mem_busy), 32'd0);
        chk("wri_cmd", 32'(bus_cmd), 32'd5);
        chk("wri_grant", 32'(grant), 32'b010);
        step();
        chk("wri_line", 32'(line_state), 32'b000010);
        chk("wri_wait", 32'(waiting), 32'b000);
        chk("wri_err", 32'(coherence_err), 32'd0);

        // round robin from clean reset, all read_shared every cycle
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(3'b111, 3'b000, 3'b000, 3'b000);
        chk("rr0_grant", 32'(grant), 32'b001);
        chk("rr0_abort", 32'(abort), 32'd0);
        step();
        #1;
        chk("rr_blk_grant", 32'(grant), 32'b010);
        chk("rr_blk_abort", 32'(abort), 32'd1);
        wait_resp(n_wait);
        chk("rr_resp_abort", 32'(abort), 32'd0);
        step();
        chk("rr1_grant", 32'(grant), 32'b010);
        chk("rr1_abort", 32'(abort), 32'd0);
        step();
        wait_resp(n_wait);
        step();
        chk("rr2_grant", 32'(grant), 32'b100);
        chk("rr2_abort", 32'(abort), 32'd0);
        step();
        drive(3'b000, 3'b000, 3'b000, 3'b000);
        chk("pre_rst_wait", 32'(waiting), 32'b100);
        chk("pre_rst_busy", 32'(mem_busy), 32'd1);

        // reset mid-transaction drops the pending response
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_line", 32'(line_state), 32'h0);
        chk("mid_wait", 32'(waiting), 32'h0);
        chk("mid_busy", 32'(mem_busy), 32'd0);
        chk("mid_cmd", 32'(bus_cmd), 32'd0);
        n_resp = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus_cmd == 4'd8) n_resp++;
            step();
        end
        chk("mid_no_resp", 32'(n_resp), 32'd0);

        // silent shared evict proceeds despite an aborted cycle
        drive(3'b001, 3'b000, 3'b000, 3'b000);
        step();
        drive(3'b000, 3'b000, 3'b000, 3'b000);
        wait_resp(n_wait);
        step();
        chk("ev_pre_line", 32'(line_state), 32'b000001);
        drive(3'b000, 3'b000, 3'b001, 3'b001);
        chk("ev_abort", 32'(abort), 32'd1);
        step();
        drive(3'b000, 3'b000, 3'b000, 3'b000);
        chk("ev_line", 32'(line_state), 32'h0);
        chk("final_err", 32'(coherence_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
